// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, opcode encodings
// and default operand/opcode widths.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OPT_W  = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_DONE
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request after position `last`,
// wrapping modulo N. Purely combinational.
module rr_pick
  import alu_pkg::*;
#(
  parameter int N = 2,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic [ID_W-1:0] pos;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    pos        = '0;
    // Offsets 1..N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      pos = ID_W'((int'(last) + k) % N);
      if (!any && req[pos]) begin
        any             = 1'b1;
        gnt_onehot[pos] = 1'b1;
        gnt_idx         = pos;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// grant, one operation in flight, and a registered result held until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OPT_W   = DEF_OPT_W,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OPT_W-1:0]   req_opt,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [DATA_W-1:0]          resp_out,
  output logic                       resp_zero,
  output logic                       resp_negative,
  output logic                       resp_carry,
  output logic [OPT_W-1:0]           alu_opt,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic                       alu_zero,
  input  logic                       alu_negative,
  input  logic                       alu_carry,
  output logic                       busy
);

  // Handshake: a transfer happens on a side exactly in the cycle where both
  // valid and ready are high at the rising edge; ready never waits on anything
  // but the current valids and FSM state, and a request not yet accepted may
  // be withdrawn freely.
  arb_state_t          state_q;
  logic [ID_W-1:0]     last_q, id_q;
  logic [OPT_W-1:0]    opt_q;
  logic [DATA_W-1:0]   a_q, b_q, out_q;
  logic                zero_q, neg_q, carry_q, valid_q, busy_q;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                accept;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last       (last_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign req_ready = (state_q == ARB_IDLE && !reset && pick_any) ? pick_onehot : '0;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      opt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            opt_q   <= req_opt[int'(pick_idx)*OPT_W +: OPT_W];
            a_q     <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
            b_q     <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
            id_q    <= pick_idx;
            last_q  <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          out_q   <= alu_out;
          zero_q  <= alu_zero;
          neg_q   <= alu_negative;
          carry_q <= alu_carry;
          valid_q <= 1'b1;
          state_q <= ARB_DONE;
        end
        ARB_DONE: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // The ALU sees the latched operands at all times; outside EXEC its result is ignored.
  assign alu_opt       = opt_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign resp_valid    = valid_q;
  assign resp_id       = id_q;
  assign resp_out      = out_q;
  assign resp_zero     = zero_q;
  assign resp_negative = neg_q;
  assign resp_carry    = carry_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomised checks of alu_arbiter (2 requesters) plus a
// 3-requester instance for wrap-around grant order.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  req_opt;
  logic [63:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [0:0]  resp_id;
  logic [31:0] resp_out;
  logic        resp_zero, resp_negative, resp_carry;
  logic [3:0]  alu_opt;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_negative, alu_carry;
  logic        busy;

  logic [2:0]  req_valid3, req_ready3;
  logic [11:0] req_opt3;
  logic [95:0] req_a3, req_b3;
  logic        resp_valid3, resp_ready3;
  logic [1:0]  resp_id3;
  logic [31:0] resp_out3;
  logic        resp_zero3, resp_negative3, resp_carry3;
  logic [3:0]  alu_opt3;
  logic [31:0] alu_a3, alu_b3, alu_out3;
  logic        alu_zero3, alu_negative3, alu_carry3;
  logic        busy3;

  // Reference ALU beside the arbiter: {carry, negative, zero, out}.
  function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      ALU_ADD: begin r = a + b; c = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; c = (a < b); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {c, r[31], (r == 32'd0), r};
  endfunction

  assign {alu_carry, alu_negative, alu_zero, alu_out}     = alu_f(alu_opt, alu_a, alu_b);
  assign {alu_carry3, alu_negative3, alu_zero3, alu_out3} = alu_f(alu_opt3, alu_a3, alu_b3);

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opt(req_opt), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_zero(resp_zero), .resp_negative(resp_negative),
    .resp_carry(resp_carry), .alu_opt(alu_opt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .busy(busy)
  );

  alu_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_opt(req_opt3), .req_a(req_a3), .req_b(req_b3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_id(resp_id3),
    .resp_out(resp_out3), .resp_zero(resp_zero3), .resp_negative(resp_negative3),
    .resp_carry(resp_carry3), .alu_opt(alu_opt3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_out(alu_out3), .alu_zero(alu_zero3), .alu_negative(alu_negative3),
    .alu_carry(alu_carry3), .busy(busy3)
  );

  typedef struct packed {
    logic        id;
    logic [3:0]  opt;
    logic [31:0] a;
    logic [31:0] b;
    logic [34:0] res;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  logic grant_log[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   m_state;
  logic m_last;
  int   cyc_n    = 0;
  bit   lat_done = 1'b0;
  logic [31:0] last_out;
  logic        last_id, last_z, last_n, last_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rr_exp(input logic [1:0] v, input logic last);
    logic f;
    f = ~last;
    if (v[f]) return f ? 2'b10 : 2'b01;
    if (v[last]) return last ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opt[i*4 +: 4]  = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_last   = 1'b1;
    lat_done = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: check both sides against the model, then advance it.
  task automatic cyc();
    logic [1:0] er;
    exp_t       e;
    int         g;
    #1;
    er = (m_state == 0) ? rr_exp(req_valid, m_last) : 2'b00;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_state != 0);
    chk("resp_valid", resp_valid, m_state == 2);
    if (m_state == 1 && exp_q.size() > 0) begin
      e = exp_q[exp_q.size()-1];
      chk("alu_opt", alu_opt, e.opt);
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        e = exp_q[0];
        if (!lat_done) begin
          chk("latency", cyc_n - e.cyc, 2);
          lat_done = 1'b1;
        end
        chk("resp_id", resp_id, e.id);
        chk("resp_out", resp_out, e.res[31:0]);
        chk("resp_zero", resp_zero, e.res[32]);
        chk("resp_negative", resp_negative, e.res[33]);
        chk("resp_carry", resp_carry, e.res[34]);
        if (resp_ready) begin
          last_out = resp_out; last_id = resp_id[0];
          last_z = resp_zero; last_n = resp_negative; last_c = resp_carry;
          void'(exp_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
    if (req_ready != 2'b00) grant_log.push_back(req_ready[1]);
    if (er != 2'b00) begin
      g = er[1] ? 1 : 0;
      e.id  = g[0];
      e.opt = req_opt[g*4 +: 4];
      e.a   = req_a[g*32 +: 32];
      e.b   = req_b[g*32 +: 32];
      e.res = alu_f(e.opt, e.a, e.b);
      e.cyc = cyc_n;
      exp_q.push_back(e);
      m_last  = g[0];
      m_state = 1;
    end else if (m_state == 1) m_state = 2;
    else if (m_state == 2 && resp_ready) m_state = 0;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (m_state == 0 && exp_q.size() == 0) break;
      cyc();
    end
    chk("drain_done", (m_state == 0) && (exp_q.size() == 0), 1);
  endtask

  task automatic op3(input logic [1:0] exp_id, input logic [31:0] exp_out);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (req_ready3 != 3'b000) begin
        seen = 1'b1;
        chk("n3_req_ready", req_ready3, 3'b001 << exp_id);
      end
      @(negedge clk);
    end
    chk("n3_grant_seen", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (resp_valid3) begin
        seen = 1'b1;
        chk("n3_resp_id", resp_id3, exp_id);
        chk("n3_resp_out", resp_out3, exp_out);
      end
      @(negedge clk);
    end
    chk("n3_resp_seen", seen, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b11; req_opt = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    req_valid3 = '0; req_opt3 = {3{ALU_ADD}}; req_a3 = '0; req_b3 = '0; resp_ready3 = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_out", resp_out, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_busy3", busy3, 0);
    reset = 1'b0; req_valid = 2'b00;
    @(negedge clk);

    // Reset while EXEC is in progress drops the op
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid = 2'b01; resp_ready = 1'b1;
    cyc();
    chk("t1_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_resp_valid", resp_valid, 0);
    chk("t1_req_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_req(0, ALU_SUB, 32'd3, 32'd3);
    set_req(1, ALU_SUB, 32'd3, 32'd3);
    req_valid = 2'b11;
    #1;
    chk("t1_first_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    run_idle(10);
    chk("t1_id", last_id, 0);

    // Single ADD from requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    run_idle(10);
    chk("t2_out", last_out, 32'd12);
    chk("t2_zero", last_z, 0);
    chk("t2_id", last_id, 0);

    set_req(1, ALU_SUB, 32'd10, 32'd3);
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    run_idle(10);
    chk("sub_out", last_out, 32'd7);
    chk("sub_id", last_id, 1);

    // Contention: alternate grants
    set_req(0, ALU_SUB, 32'd3, 32'd3);
    set_req(1, ALU_SUB, 32'd3, 32'd3);
    grant_log.delete();
    req_valid = 2'b11;
    for (int k = 0; k < 20 && grant_log.size() < 4; k++) cyc();
    req_valid = 2'b00;
    run_idle(10);
    chk("t3_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("t3_grant_order", grant_log[i], i % 2);
    chk("t3_out", last_out, 0);
    chk("t3_zero", last_z, 1);

    // Backpressure holds the result
    set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    req_valid = 2'b01; resp_ready = 1'b0;
    cyc();
    req_valid = 2'b11;
    repeat (6) cyc();
    chk("t4_out", resp_out, 32'h8000_0000);
    chk("t4_carry", resp_carry, 1);
    chk("t4_negative", resp_negative, 1);
    chk("t4_req_ready", req_ready, 0);
    req_valid = 2'b00; resp_ready = 1'b1;
    run_idle(10);

    // Withdrawn request is never served
    grant_log.delete();
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(1, ALU_ADD, 32'd2, 32'd2);
    req_valid = 2'b01; resp_ready = 1'b0;
    cyc();
    req_valid = 2'b10;
    cyc();
    cyc();
    req_valid = 2'b00; resp_ready = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("t5_grants", grant_log.size(), 1);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Illegal opcode passes through; reference ALU returns 0
    set_req(0, 4'hF, 32'd5, 32'd6);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    run_idle(10);
    chk("illegal_out", last_out, 0);
    chk("illegal_zero", last_z, 1);

    // Randomised traffic with random backpressure
    for (int k = 0; k < 40; k++) begin
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = 1'($urandom_range(0, 1));
      set_req(0, 4'($urandom_range(0, 5)), $urandom, $urandom);
      set_req(1, 4'($urandom_range(0, 5)), $urandom, $urandom);
      cyc();
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    run_idle(10);

    // Three requesters: lone req2, then full rotation from last=2
    req_valid3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      req_a3[64 +: 32] = 32'(i);
      req_b3[64 +: 32] = 32'd10;
      op3(2'd2, 32'(i + 10));
    end
    for (int j = 0; j < 3; j++) begin
      req_a3[j*32 +: 32] = 32'(100 + j);
      req_b3[j*32 +: 32] = 32'(j);
    end
    req_valid3 = 3'b111;
    op3(2'd0, 32'd100);
    op3(2'd1, 32'd102);
    op3(2'd2, 32'd104);
    req_valid3 = 3'b000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
